// File: rtl/uart_rx_pkg.sv
// Shared UART constants: one-hot state encodings and bit-period derivation,
// common to the receiver and transmitter.
`timescale 1ns/1ps
package uart_rx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;

    function automatic int unsigned bit_period(input int unsigned clk_freq,
                                               input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned half_period(input int unsigned clk_freq,
                                                input int unsigned baud);
        return bit_period(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte outputs of the UART receiver.
`timescale 1ns/1ps
interface uart_rx_if;
    logic       uartrx;
    logic       uart_rx_done;
    logic [7:0] odat;
    logic       frame_err;

    modport master (output uartrx, input uart_rx_done, odat, frame_err);
    modport slave  (input uartrx, output uart_rx_done, odat, frame_err);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable
// reset value so an idle-high line does not look like a start edge.
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: falling-edge start detect, mid-bit sampling, and
// one-cycle done / frame-error pulses.
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge on the synchronized line
//   START | counting half a bit to re-check the start bit at its centre
//   DATA  | sampling 8 data bits LSB first, one per full bit period
//   STOP  | sampling the stop bit at its centre, then back to IDLE
`timescale 1ns/1ps
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int UARTBaud = 115200,
    parameter int CLKFreq  = 50_000_000
) (
    input logic      sys_clk,
    input logic      rst_n,
    uart_rx_if.slave bus
);
    localparam int unsigned P     = bit_period(CLKFreq, UARTBaud);
    localparam int unsigned H     = half_period(CLKFreq, UARTBaud);
    localparam int unsigned CNT_W = (P > 2) ? $clog2(P) : 1;

    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(P - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H - 1);

    logic              w_rx_s;
    logic              r_rx_prev;
    uart_state_e       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [7:0]        r_odat;
    logic              r_done;
    logic              r_ferr;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .i_d     (bus.uartrx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_odat    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_rx_prev <= 1'b1;
        end else begin
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
            r_rx_prev <= w_rx_s;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (r_rx_prev && !w_rx_s) begin
                        r_state   <= ST_START;
                        r_bit_idx <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == H_LAST) begin
                        r_cnt   <= '0;
                        // A line already back high at mid-start is a glitch.
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == P_LAST) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == P_LAST) begin
                        // Leaving at mid-stop leaves half a bit to catch a back-to-back start.
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                        if (w_rx_s) begin
                            r_done <= 1'b1;
                            r_odat <= r_shift;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.uart_rx_done = r_done;
    assign bus.frame_err    = r_ferr;
    assign bus.odat         = r_odat;
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter UARTBaud, default 115200: line baud rate.
REQ-002 Parameter CLKFreq, default 50_000_000: sys_clk frequency in Hz.
REQ-003 sys_clk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 uartrx  input  1  UART RX line; asynchronous to sys_clk; idle high.
REQ-006 uart_rx_done  output  1  one-cycle pulse when a frame with a valid stop bit is received.
REQ-007 odat  output  8  last correctly received byte; valid from the uart_rx_done cycle until the next done.
REQ-008 frame_err  output  1  one-cycle pulse when the stop bit samples low.

Function
REQ-009 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-010 Bit period P SHALL be CLKFreq/UARTBaud cycles (integer division; 434 at defaults); half period H SHALL be P/2 (217).
REQ-011 uartrx SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rx_s.
REQ-012 The state machine SHALL use one-hot states IDLE=0001, START=0010, DATA=0100, STOP=1000.
REQ-013 IDLE SHALL exit to START only on a falling edge of rx_s (previous rx_s 1, current 0); the bit counter SHALL be held at 0 in IDLE.
REQ-014 START SHALL count 0..H-1; at H-1 it SHALL sample rx_s: 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no output activity).
REQ-015 DATA SHALL count 0..P-1 per bit; at P-1 it SHALL store rx_s into shift bit [bit_idx] and increment the 3-bit bit_idx; after bit_idx 7 is stored -> STOP.
REQ-016 STOP SHALL count 0..P-1; at P-1 it SHALL sample rx_s and return to IDLE in the same transition.
REQ-017 Stop sample 1: the next cycle SHALL assert uart_rx_done for exactly 1 cycle with odat updated to the assembled byte in that same cycle.
REQ-018 Stop sample 0: the next cycle SHALL assert frame_err for exactly 1 cycle; odat SHALL remain unchanged; uart_rx_done SHALL NOT assert.
REQ-019 After a frame_err, a new frame SHALL require rx_s to return high and then fall again.
REQ-020 uart_rx_done and frame_err SHALL never assert in the same cycle.
REQ-021 Back-to-back frames (next start edge immediately after the stop bit) SHALL be received without loss, since IDLE is re-entered at mid-stop.
REQ-022 bit_idx SHALL be cleared on entry to START.
REQ-023 The receiver SHALL correctly receive frames whose transmitter baud rate deviates by up to ±2 % from UARTBaud.
REQ-024 Latency from the mid-point of the stop bit on the synchronized line to uart_rx_done SHALL be 1 cycle, plus 2 cycles of synchronizer delay.

Reset
REQ-025 On rst_n low (asynchronous) the block SHALL reset: state=IDLE, counter=0, bit_idx=0, shift register=0, odat=0x00, uart_rx_done=0, frame_err=0, synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done or err pulse; after release the receiver SHALL wait for a fresh falling edge.

Structure
REQ-027 The state encodings and the P/H derivation from CLKFreq/UARTBaud SHALL live in a shared UART constants include used by both uart_tx and uart_rx.
REQ-028 The input synchronizer SHALL be the sub-module sync_2ff (1-bit, reset value 1); the remaining logic stays flat in uart_rx.

Verification
REQ-029 Send 0x55 at 115200 -> exactly one uart_rx_done pulse, odat=0x55, frame_err never asserted.
REQ-030 Send 0xA3, 0x00, 0xFF back-to-back with no idle gap -> three done pulses, odat sequence 0xA3, 0x00, 0xFF.
REQ-031 Drive uartrx low for 100 cycles, then high -> no done, no frame_err, state returns to IDLE.
REQ-032 Send 0x3C with the stop bit forced low -> one frame_err pulse, no done, odat keeps its prior value; a following 0x12 is received correctly.
REQ-033 Assert rst_n low during data bit 4 of 0x96 -> no pulses, odat=0x00; a subsequent 0x69 yields done with odat=0x69.
REQ-034 Loop uart_tx.uarttx to uartrx and send 256 bytes 0x00..0xFF, repeated at ±2 % baud offset -> every byte received in order, no frame_err.
